// File: rtl/tv_pkg.sv
// Shared types and constants for the on-board test-vector sequencer.
package tv_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_WAIT,
      S_CHECK,
      S_DONE
   } tv_state_e;

   localparam int TV_ERR_W = 16;
   localparam logic [TV_ERR_W-1:0] TV_ERR_MAX = '1;

endpackage

// File: rtl/tv_vec_mem.sv
// Vector store: DEPTH words of {inputs, expected}, written from the load
// port and read combinationally at the sequencer index. Not reset.
module tv_vec_mem #(
   parameter int W     = 4,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/tv_sequencer.sv
// Applies stored vectors to a combinational DUT, waits SETTLE cycles,
// compares the response and accumulates a saturating mismatch count.
module tv_sequencer
   import tv_pkg::*;
#(
   parameter int NIN    = 3,
   parameter int NOUT   = 1,
   parameter int DEPTH  = 16,
   parameter int SETTLE = 2,
   parameter int ERR_W  = TV_ERR_W,
   localparam int AW    = $clog2(DEPTH),
   localparam int VW    = NIN + NOUT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_we,
   input  logic [AW-1:0]    load_addr,
   input  logic [VW-1:0]    load_data,
   input  logic [AW:0]      vec_count,
   input  logic             start,
   output logic [NIN-1:0]   dut_in,
   input  logic [NOUT-1:0]  dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] errors,
   output logic             first_err_valid,
   output logic [AW-1:0]    first_err_idx
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);
   localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(TV_ERR_MAX);

   tv_state_e        state_q, state_d;
   logic [AW:0]      idx_q, idx_d;
   logic [AW:0]      n_q, n_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NOUT-1:0]  exp_q, exp_d;
   logic [NIN-1:0]   dut_in_q, dut_in_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             fev_q, fev_d;
   logic [AW-1:0]    fei_q, fei_d;

   logic [VW-1:0]    rd_word;
   logic             mismatch;

   tv_vec_mem #(
      .W     (VW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (load_we & ~busy_q),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (idx_q[AW-1:0]),
      .rdata (rd_word)
   );

   assign mismatch = (dut_out != exp_q);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      n_d      = n_q;
      cnt_d    = cnt_q;
      exp_d    = exp_q;
      dut_in_d = dut_in_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      err_d    = err_q;
      fev_d    = fev_q;
      fei_d    = fei_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               n_d    = (vec_count > DEPTH_N) ? DEPTH_N : vec_count;
               idx_d  = '0;
               err_d  = '0;
               fev_d  = 1'b0;
               fei_d  = '0;
               done_d = 1'b0;
               pass_d = 1'b0;
               if (n_d == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end else begin
                  state_d = S_APPLY;
                  busy_d  = 1'b1;
               end
            end
         end
         S_APPLY: begin
            dut_in_d = rd_word[VW-1:NOUT];
            exp_d    = rd_word[NOUT-1:0];
            cnt_d    = CNT_LOAD;
            state_d  = (SETTLE == 0) ? S_CHECK : S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_CHECK;
            else cnt_d = cnt_q - 1'b1;
         end
         S_CHECK: begin
            if (mismatch) begin
               if (err_q != ERR_MAX) err_d = err_q + 1'b1;
               if (!fev_q) begin
                  fev_d = 1'b1;
                  fei_d = idx_q[AW-1:0];
               end
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == n_q - 1'b1) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               state_d = S_APPLY;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         n_q      <= '0;
         cnt_q    <= '0;
         exp_q    <= '0;
         dut_in_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         fev_q    <= 1'b0;
         fei_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         n_q      <= n_d;
         cnt_q    <= cnt_d;
         exp_q    <= exp_d;
         dut_in_q <= dut_in_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         fev_q    <= fev_d;
         fei_q    <= fei_d;
      end
   end

   assign dut_in          = dut_in_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign errors          = err_q;
   assign first_err_valid = fev_q;
   assign first_err_idx   = fei_q;

endmodule
